// File: rtl/bs_pkg.sv
// bs_pkg: shared constants and helpers for the bus driver endpoint
package bs_pkg;
  localparam int ERR_MISROUTE = 0;
  localparam int ERR_RX_OVF = 1;
  localparam int ERR_POP_UNF = 2;
  localparam logic [7:0] BCAST_DEFAULT = 8'hFF;
  function automatic logic [63:0] get_id(input logic [63:0] pkt, input int unsigned bits, input int unsigned id_bits);
    return (pkt >> (bits - id_bits)) & ((64'd1 << id_bits) - 64'd1);
  endfunction
endpackage

// File: rtl/bs_fifo_fwft.sv
// bs_fifo_fwft: first-word-fall-through FIFO with optional write-when-full-with-read
module bs_fifo_fwft #(
  parameter int bits = 32,
  parameter int depth = 8,
  parameter bit accept_when_full_with_read = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [bits-1:0]          wr_data,
  input  logic                     rd_en,
  output logic [bits-1:0]          rd_data,
  output logic [$clog2(depth):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;
  logic [bits-1:0] mem_q [depth];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic do_wr, do_rd;
  assign full = count_q == CW'(depth);
  assign empty = count_q == '0;
  assign count = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  // a read frees the slot in the same cycle only when the owner allows it
  always_comb begin
    do_rd = rd_en & !empty;
    do_wr = wr_en & (!full | (accept_when_full_with_read & do_rd));
    wr_ptr_d = wr_ptr_q + AW'(do_wr);
    rd_ptr_d = rd_ptr_q + AW'(do_rd);
    count_d = count_q + CW'(do_wr) - CW'(do_rd);
  end
  // pointer and occupancy state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  // storage needs no reset; contents are ignored while empty
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/bs_drvr_endpoint.sv
// bs_drvr_endpoint: driver-side bus endpoint bridging host valid/ready to arbiter pop/push
module bs_drvr_endpoint
  import bs_pkg::*;
#(
  parameter int bits = 32,
  parameter int depth = 8,
  parameter int id_bits = 8,
  parameter int unsigned drvr_id = 0,
  parameter logic [id_bits-1:0] broadcast = id_bits'(BCAST_DEFAULT)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [bits-1:0]        tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic                   pndng,
  input  logic                   pop,
  output logic [bits-1:0]        D_pop,
  input  logic                   push,
  input  logic [bits-1:0]        D_push,
  output logic [bits-1:0]        rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic [$clog2(depth):0] tx_count,
  output logic [$clog2(depth):0] rx_count,
  output logic [15:0]            drop_cnt,
  output logic [2:0]             err
);
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic id_ok, room, rx_wr, drop;
  logic [id_bits-1:0] rx_id;
  logic [15:0] drop_q, drop_d;
  logic [2:0] err_q, err_d;
  assign tx_ready = !tx_full;
  assign pndng = !tx_empty;
  assign rx_valid = !rx_empty;
  assign drop_cnt = drop_q;
  assign err = err_q;
  bs_fifo_fwft #(.bits(bits), .depth(depth), .accept_when_full_with_read(1'b0)) u_tx (
    .clk(clk), .reset(reset), .wr_en(tx_valid & tx_ready), .wr_data(tx_data),
    .rd_en(pop), .rd_data(D_pop), .count(tx_count), .full(tx_full), .empty(tx_empty)
  );
  bs_fifo_fwft #(.bits(bits), .depth(depth), .accept_when_full_with_read(1'b1)) u_rx (
    .clk(clk), .reset(reset), .wr_en(rx_wr), .wr_data(D_push),
    .rd_en(rx_ready), .rd_data(rx_data), .count(rx_count), .full(rx_full), .empty(rx_empty)
  );
  // destination filter, overflow decision and sticky error / drop accounting
  always_comb begin
    rx_id = id_bits'(get_id(64'(D_push), bits, id_bits));
    id_ok = (rx_id == id_bits'(drvr_id)) | (rx_id == broadcast);
    room = !rx_full | (rx_valid & rx_ready);
    rx_wr = push & id_ok & room;
    drop = push & (!id_ok | !room);
    drop_d = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    err_d = err_q;
    err_d[ERR_MISROUTE] = err_q[ERR_MISROUTE] | (push & !id_ok);
    err_d[ERR_RX_OVF] = err_q[ERR_RX_OVF] | (push & id_ok & !room);
    err_d[ERR_POP_UNF] = err_q[ERR_POP_UNF] | (pop & tx_empty);
  end
  // status registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_q <= '0;
      err_q <= '0;
    end else begin
      drop_q <= drop_d;
      err_q <= err_d;
    end
  end
endmodule

// File: doc/bs_drvr_endpoint.md
Name: bs_drvr_endpoint

Overview:
- Driver-side endpoint of the parallel bus generator/arbiter: one instance per driver per bus.
- Presents the pndng / pop / D_pop source interface that the arbiter drains.
- Accepts the push / D_push sink interface that the arbiter fills.
- Bridges both directions to a host valid/ready interface through two FWFT FIFOs, with destination filtering and error counters on the receive path.

Parameters:
- bits, 32, packet width; destination ID in bits[bits-1 -: id_bits].
- depth, 8, entries per FIFO; power of two, >= 2.
- id_bits, 8, destination ID field width.
- drvr_id, 0, this endpoint's ID.
- broadcast, {8{1'b1}}, ID value accepted by every endpoint.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- tx_data  in  bits  host packet to send.
- tx_valid  in  1  host offers tx_data.
- tx_ready  out  1  TX FIFO not full.
- pndng  out  1  TX FIFO non-empty (to arbiter).
- pop  in  1  arbiter consumes head of TX FIFO.
- D_pop  out  bits  TX FIFO head; valid while pndng = 1.
- push  in  1  arbiter delivers D_push.
- D_push  in  bits  delivered packet.
- rx_data  out  bits  RX FIFO head.
- rx_valid  out  1  RX FIFO non-empty.
- rx_ready  in  1  host consumes rx_data.
- tx_count  out  $clog2(depth)+1  TX occupancy.
- rx_count  out  $clog2(depth)+1  RX occupancy.
- drop_cnt  out  16  packets discarded on the RX path (misroute or overflow).
- err  out  3  sticky flags: {pop_underflow, rx_overflow, misroute}.

Behaviour:
- Reset (reset = 0, async):
  - Pointers, counts, drop_cnt and err clear to 0.
  - pndng = 0, rx_valid = 0, tx_ready = 1.
  - D_pop and rx_data are don't-care while their FIFO is empty; the bench must not check them.
- TX write: tx_valid & tx_ready at edge k stores tx_data.
  - pndng = 1 and D_pop = data from cycle k+1 (one-cycle latency).
  - tx_ready = (tx_count < depth); it is computed from the registered count only.
  - A pop in the same cycle does not free a slot for a write when full.
- TX read: pop & pndng at an edge advances the read pointer. The next entry appears on D_pop the following cycle, or pndng drops.
- Pop while empty: no pointer change; sets err[2] (sticky).
- Simultaneous TX write and pop when not full and not empty: tx_count unchanged, both operations take effect.
- RX filter, evaluated on push:
  - Accept if D_push[bits-1 -: id_bits] == drvr_id or == broadcast.
  - Otherwise discard, set err[0], increment drop_cnt.
- RX accept:
  - Write if rx_count < depth, or if rx_count == depth and rx_valid & rx_ready in the same cycle (slot freed this cycle).
  - Otherwise discard, set err[1], increment drop_cnt.
- RX read: rx_valid & rx_ready advances the read pointer. rx_valid/rx_data are FWFT with one-cycle write-to-visible latency.
- Pointers wrap modulo depth. Counts range 0..depth.
- drop_cnt saturates at 16'hFFFF.
- A misrouted packet never occupies an RX slot.
- err bits clear only on reset.
- Reset mid-transfer: all FIFO contents are lost and the interfaces return to reset values immediately (asynchronous). Deassertion is synchronous to the design's clk domain by the system reset synchroniser.

Decomposition:
- Package bs_pkg:
  - id-field extraction function: get_id(pkt), returning bits[bits-1 -: id_bits].
  - err bit index constants: ERR_MISROUTE = 0, ERR_RX_OVF = 1, ERR_POP_UNF = 2.
  - default broadcast constant.
- Sub-module bs_fifo_fwft (parameters bits, depth): memory, pointers, count, wr_en/rd_en, full/empty.
  - Instantiated twice (TX, RX).
  - Takes a wr_en that the parent has already qualified, plus an accept_when_full_with_read option for the RX path.

Test Plan:
- Reset → tx_ready = 1, pndng = 0, rx_valid = 0, drop_cnt = 0, err = 3'b000.
- Host writes 32'h0301_0000 to 32'h0301_0007 (8 packets, depth 8) with no pop → tx_ready = 0 after the 8th write; pndng = 1; D_pop = 32'h0301_0000. Then 8 pops → D_pop steps through the same 8 values in order; pndng = 0 after the last pop.
- drvr_id = 5: push 32'h05AA_0001, 32'hFFAA_0002, 32'h07AA_0003 → rx_data delivers 32'h05AA_0001 then 32'hFFAA_0002 only; drop_cnt = 1; err = 3'b001.
- RX full (8 entries):
  - Push 32'h0500_0009 with rx_ready = 0 → dropped; drop_cnt + 1; err[1] = 1; rx_count = 8.
  - Next push 32'h0500_000A with rx_ready = 1 → accepted; rx_count stays 8; 32'h0500_000A is the last entry read out.
- Pop with pndng = 0 → err[2] = 1; tx_count stays 0.
- Same-cycle TX write (32'h0100_0011) and pop at tx_count = 3 → tx_count stays 3; data order preserved.
- Reset asserted between pushes → all counts = 0 at once; rx_valid = 0 at once.
